clk_phase_gen: RTL and testbench

- Parametrised multi-channel clock generator for the processor top level.
- Replaces the fixed divide-by-2 clock divider with NUM_CH independently programmable 50%-duty divided clocks.
- Each channel also produces registered rise/fall strobes for clock-enable use, and a phase offset applied on a global align.
- Channels are reconfigured at runtime through a valid/ready port. A new ratio takes effect only at a falling edge, so output clocks never glitch.

---
 rtl/clk_phase_gen_if.sv | 22 ++
 rtl/clk_phase_gen.sv | 117 +++++++++++
 tb/tb_clk_phase_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/clk_phase_gen_if.sv
// Configuration port of clk_phase_gen: valid/ready request carrying
// channel select, new half-period and phase start value.
interface clk_phase_gen_if #(
   parameter int CH_W  = 2,
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_half;
   logic [CNT_W-1:0] cfg_phase;

   modport master (
      output cfg_valid, cfg_ch, cfg_half, cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_half, cfg_phase,
      output cfg_ready
   );
endinterface

// File: rtl/clk_phase_gen.sv
// Multi-channel 50%-duty clock divider with rise/fall strobes,
// runtime-reconfigurable ratio and phase applied on align.
// Ports: clock, reset (async, high), enable, align, cfg (slave),
//        clk_out, rise_pulse, fall_pulse, pending (one bit per channel).
module clk_phase_gen #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 8,
   parameter int DEFAULT_HALF = 1,
   parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              align,
   clk_phase_gen_if.slave    cfg,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic [NUM_CH-1:0] pending
);

   localparam logic [CNT_W-1:0] DEF_H =
      CNT_W'((DEFAULT_HALF < 1) ? 1 : DEFAULT_HALF);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q    [NUM_CH];
   logic [CNT_W-1:0] active_q [NUM_CH];
   logic [CNT_W-1:0] staged_q [NUM_CH];
   logic [CNT_W-1:0] phase_q  [NUM_CH];
   logic [NUM_CH-1:0] clk_q, rise_q, fall_q, pend_q;

   logic [CNT_W-1:0] hm1_cur [NUM_CH];
   logic [CNT_W-1:0] start_v [NUM_CH];
   logic [NUM_CH-1:0] fire;
   logic [CNT_W-1:0] cfg_h;
   logic ready;

   assign clk_out    = clk_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign pending    = pend_q;
   assign cfg.cfg_ready = ready;

   // Out-of-range channel selects match no channel, so they are
   // accepted (ready stays high) and discarded.
   always_comb begin
      ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg.cfg_ch == CH_W'(i) && pend_q[i]) ready = 1'b0;
      end
   end

   always_comb begin
      cfg_h = (cfg.cfg_half == '0) ? ONE : cfg.cfg_half;
      fire  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         fire[i] = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(i));
      end
   end

   // staged_q is always >= 1, so h_new-1 never underflows; on align
   // the start count is clamped into the new period.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         hm1_cur[i] = ((active_q[i] == '0) ? ONE : active_q[i]) - ONE;
         start_v[i] = (phase_q[i] > staged_q[i] - ONE)
                    ? staged_q[i] - ONE : phase_q[i];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         pend_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            active_q[i] <= DEF_H;
            staged_q[i] <= DEF_H;
            phase_q[i]  <= '0;
         end
      end else begin
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (align) begin
               active_q[i] <= staged_q[i];
               cnt_q[i]    <= start_v[i];
               clk_q[i]    <= 1'b0;
               pend_q[i]   <= 1'b0;
            end else if (enable) begin
               if (cnt_q[i] == hm1_cur[i]) begin
                  cnt_q[i]  <= '0;
                  clk_q[i]  <= ~clk_q[i];
                  rise_q[i] <= ~clk_q[i];
                  fall_q[i] <= clk_q[i];
                  // New ratio only at a falling edge: no runt pulse.
                  if (clk_q[i] && pend_q[i]) begin
                     active_q[i] <= staged_q[i];
                     pend_q[i]   <= 1'b0;
                  end
               end else begin
                  cnt_q[i] <= cnt_q[i] + ONE;
               end
            end
            // A request in the align cycle stays staged for later.
            if (fire[i]) begin
               staged_q[i] <= cfg_h;
               phase_q[i]  <= cfg.cfg_phase;
               pend_q[i]   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen: vector table for the main
// sequence, hand sequences for freeze and async reset.
module tb_clk_phase_gen;

   logic clock = 1'b0;
   logic reset, enable, align;
   logic [3:0] clk_out, rise_pulse, fall_pulse, pending;

   clk_phase_gen_if #(.CH_W(2), .CNT_W(8)) cfg ();

   clk_phase_gen #(
      .NUM_CH(4), .CNT_W(8), .DEFAULT_HALF(1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .align      (align),
      .cfg        (cfg),
      .clk_out    (clk_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .pending    (pending)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       en;
      logic       al;
      logic       vld;
      logic [1:0] ch;
      logic [7:0] half;
      logic [7:0] ph;
      logic [3:0] clk;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] pend;
      logic       rdy;
   } vec_t;

   vec_t vq[$];
   int total = 0;
   int passed = 0;

   task automatic add(input logic en, input logic al, input logic vld,
                      input logic [1:0] ch, input logic [7:0] half,
                      input logic [7:0] ph, input logic [3:0] c,
                      input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] p, input logic rdy);
      vec_t v;
      v.en = en; v.al = al; v.vld = vld; v.ch = ch;
      v.half = half; v.ph = ph; v.clk = c; v.rise = r;
      v.fall = f; v.pend = p; v.rdy = rdy;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s step %0d: got %b expected %b",
                    name, idx, act, exp);
   endtask

   task automatic chk_all(input int idx, input logic [3:0] c,
                          input logic [3:0] r, input logic [3:0] f,
                          input logic [3:0] p, input logic rdy);
      chk("clk_out", idx, clk_out, c);
      chk("rise_pulse", idx, rise_pulse, r);
      chk("fall_pulse", idx, fall_pulse, f);
      chk("pending", idx, pending, p);
      chk("cfg_ready", idx, {3'b0, cfg.cfg_ready}, {3'b0, rdy});
   endtask

   initial begin
      // en al vld ch half ph | clk rise fall pend rdy
      add(1,0,0,0,0,0, 4'b1111,4'b1111,4'b0000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b0000,4'b0000,4'b1111,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1111,4'b1111,4'b0000,4'b0000,1);
      add(1,0,1,1,3,0, 4'b0000,4'b0000,4'b1111,4'b0010,0);
      add(1,0,1,3,1,0, 4'b1111,4'b1111,4'b0000,4'b1010,0);
      add(1,0,1,1,5,0, 4'b0000,4'b0000,4'b1111,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1101,4'b1101,4'b0000,4'b0000,1);
      add(1,0,1,2,0,0, 4'b0000,4'b0000,4'b1101,4'b0100,0);
      add(1,0,0,2,0,0, 4'b1111,4'b1111,4'b0000,4'b0100,0);
      add(1,0,0,2,0,0, 4'b0010,4'b0000,4'b1101,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1111,4'b1101,4'b0000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b0000,4'b0000,4'b1111,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1101,4'b1101,4'b0000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b0000,4'b0000,4'b1101,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1111,4'b1111,4'b0000,4'b0000,1);
      add(1,0,1,0,4,0, 4'b0010,4'b0000,4'b1101,4'b0001,0);
      add(1,0,1,2,4,2, 4'b1111,4'b1101,4'b0000,4'b0101,0);
      add(1,1,0,0,0,0, 4'b0000,4'b0000,4'b0000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1000,4'b1000,4'b0000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b0100,4'b0100,4'b1000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1110,4'b1010,4'b0000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b0111,4'b0001,4'b1000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b1111,4'b1000,4'b0000,4'b0000,1);
      add(1,0,0,0,0,0, 4'b0001,4'b0000,4'b1110,4'b0000,1);

      reset = 1'b1; enable = 1'b0; align = 1'b0;
      cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0;
      cfg.cfg_half = '0; cfg.cfg_phase = '0;
      #11;
      chk_all(-1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
      #1 reset = 1'b0;

      foreach (vq[k]) begin
         enable = vq[k].en; align = vq[k].al;
         cfg.cfg_valid = vq[k].vld; cfg.cfg_ch = vq[k].ch;
         cfg.cfg_half = vq[k].half; cfg.cfg_phase = vq[k].ph;
         @(posedge clock); #1;
         chk_all(k, vq[k].clk, vq[k].rise, vq[k].fall,
                 vq[k].pend, vq[k].rdy);
      end

      // Freeze: outputs hold, a cfg handshake still lands.
      enable = 1'b0; align = 1'b0;
      cfg.cfg_valid = 1'b1; cfg.cfg_ch = 2'd3;
      cfg.cfg_half = 8'd2; cfg.cfg_phase = 8'd0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clock); #1;
         cfg.cfg_valid = 1'b0; cfg.cfg_ch = 2'd0;
         chk("freeze_clk", 100 + n, clk_out, 4'b0001);
         chk("freeze_rise", 100 + n, rise_pulse, 4'b0000);
         chk("freeze_fall", 100 + n, fall_pulse, 4'b0000);
         chk("freeze_pend", 100 + n, pending, 4'b1000);
      end

      // Async reset between edges clears state before next edge.
      #2 reset = 1'b1;
      #1;
      chk("areset_clk", 200, clk_out, 4'b0000);
      chk("areset_pend", 200, pending, 4'b0000);
      chk("areset_rise", 200, rise_pulse, 4'b0000);
      chk("areset_fall", 200, fall_pulse, 4'b0000);
      #2 reset = 1'b0; enable = 1'b1;
      @(posedge clock); #1;
      chk_all(201, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1);
      @(posedge clock); #1;
      chk_all(202, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
